pc_unit: RTL and testbench

- Parametrised successor to the single program-counter register.
- Holds the fetch PC, generates the sequential next address, and accepts stall, branch/jump redirect and exception redirect.
- Adds a circular return-address stack (RAS) for call/return prediction.
- Sits between next-PC selection logic and instruction memory. All fetch-address state lives here.

---
 rtl/pc_unit_if.sv | 32 +++
 rtl/pc_unit.sv | 98 +++++++++
 tb/tb_pc_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// Fetch-side bundle for pc_unit: control inputs from next-PC selection
// and the registered fetch address plus return-address-stack status.
interface pc_unit_if #(
   parameter int WIDTH     = 32,
   parameter int RAS_DEPTH = 4
);
   localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

   logic             stall;
   logic             redirect_valid;
   logic [WIDTH-1:0] redirect_target;
   logic             exc_valid;
   logic             call;
   logic             ret;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_plus;
   logic [WIDTH-1:0] ras_top;
   logic [CNT_W-1:0] ras_count;
   logic             ras_empty;

   // Next-PC selection logic drives the controls and watches the PC.
   modport master (
      output stall, redirect_valid, redirect_target, exc_valid, call, ret,
      input  pc, pc_plus, ras_top, ras_count, ras_empty
   );

   // The PC unit consumes the controls and owns all fetch-address state.
   modport slave (
      input  stall, redirect_valid, redirect_target, exc_valid, call, ret,
      output pc, pc_plus, ras_top, ras_count, ras_empty
   );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch PC, computes the sequential
// successor, applies exception / redirect / stall / return selection and
// keeps a circular return-address stack for call/return prediction.
// All state changes on the falling edge of CLK.
module pc_unit #(
   parameter int               WIDTH        = 32,
   parameter int               INST_BYTES   = 4,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [31:0]      EXC_VECTOR   = 32'h0000_0180,
   parameter int               RAS_DEPTH    = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   pc_unit_if.slave   bus
);

   localparam int               PTR_W      = $clog2(RAS_DEPTH);
   localparam int               CNT_W      = PTR_W + 1;
   localparam logic [WIDTH-1:0] EXC_PC     = WIDTH'(EXC_VECTOR);
   localparam logic [WIDTH-1:0] STEP       = WIDTH'(INST_BYTES);
   // Clears the byte-offset bits below one instruction; all ones when
   // INST_BYTES is 1, so byte-granular targets pass through untouched.
   localparam logic [WIDTH-1:0] ALIGN_MASK = ~(STEP - WIDTH'(1));
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(RAS_DEPTH);

   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_ras [RAS_DEPTH];
   logic [PTR_W-1:0] r_ptr;
   logic [CNT_W-1:0] r_count;

   logic [WIDTH-1:0] w_pcPlus;
   logic [PTR_W-1:0] w_topIdx;
   logic [WIDTH-1:0] w_top;
   logic             w_popValid;
   logic             w_full;

   // Sequential successor and stack-top lookup. The pointer names the next
   // free slot, so the newest entry sits one below it (wrapping). An empty
   // stack reports zero so stale or reset entries never leak out.
   always_comb begin
      w_pcPlus   = r_pc + STEP;
      w_topIdx   = r_ptr - PTR_W'(1);
      w_top      = (r_count != '0) ? r_ras[w_topIdx] : '0;
      w_popValid = bus.ret && (r_count != '0);
      w_full     = (r_count == FULL_COUNT);
   end

   assign bus.pc        = r_pc;
   assign bus.pc_plus   = w_pcPlus;
   assign bus.ras_top   = w_top;
   assign bus.ras_count = r_count;
   assign bus.ras_empty = (r_count == '0);

   // PC selection and return-stack maintenance. An exception wins outright
   // and flushes the stack; a redirect beats stall for the PC, but stall
   // still freezes the stack. call+ret together swap the top entry in place
   // while the PC takes the old top, which is the tail-call style pattern.
   always_ff @(negedge CLK or posedge RESET) begin
      if (RESET) begin
         r_pc    <= RESET_VECTOR;
         r_ptr   <= '0;
         r_count <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            r_ras[i] <= '0;
         end
      end else if (bus.exc_valid) begin
         r_pc    <= EXC_PC;
         r_ptr   <= '0;
         r_count <= '0;
      end else begin
         if (bus.redirect_valid) begin
            r_pc <= bus.redirect_target & ALIGN_MASK;
         end else if (bus.stall) begin
            r_pc <= r_pc;
         end else if (w_popValid) begin
            r_pc <= w_top & ALIGN_MASK;
         end else begin
            r_pc <= w_pcPlus;
         end

         if (!bus.stall) begin
            if (bus.call && w_popValid) begin
               r_ras[w_topIdx] <= w_pcPlus;
            end else if (bus.call) begin
               r_ras[r_ptr] <= w_pcPlus;
               r_ptr        <= r_ptr + PTR_W'(1);
               if (!w_full) begin
                  r_count <= r_count + CNT_W'(1);
               end
            end else if (w_popValid) begin
               r_ptr   <= r_ptr - PTR_W'(1);
               r_count <= r_count - CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: table of directed vectors with hand-computed
// PC / stack expectations, plus hand-written reset sequences.
module tb_pc_unit;

   localparam int WIDTH     = 32;
   localparam int RAS_DEPTH = 4;

   logic CLK;
   logic RESET;

   pc_unit_if #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) bus ();

   pc_unit #(
      .WIDTH       (WIDTH),
      .INST_BYTES  (4),
      .RESET_VECTOR(32'h0),
      .EXC_VECTOR  (32'h0000_0180),
      .RAS_DEPTH   (RAS_DEPTH)
   ) dut (
      .CLK  (CLK),
      .RESET(RESET),
      .bus  (bus)
   );

   typedef struct {
      logic        stall;
      logic        rv;
      logic [31:0] target;
      logic        exc;
      logic        call;
      logic        ret;
      logic [31:0] expPc;
      logic [31:0] expTop;
      int          expCount;
   } vec_t;

   vec_t vecs[$];
   int   numChecks;
   int   numFails;

   // Free-running clock; the DUT acts on falling edges, the bench samples on rising edges.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic addVec(input logic st, input logic rv, input logic [31:0] tgt,
                         input logic ex, input logic cl, input logic rt,
                         input logic [31:0] pc, input logic [31:0] top, input int cnt);
      vec_t v;
      v.stall = st; v.rv = rv; v.target = tgt; v.exc = ex; v.call = cl; v.ret = rt;
      v.expPc = pc; v.expTop = top; v.expCount = cnt;
      vecs.push_back(v);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      numChecks++;
      if (act !== exp) begin
         numFails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic checkState(input string tag, input logic [31:0] pc, input logic [31:0] top,
                             input int cnt);
      checkOutput({tag, " pc"}, bus.pc, pc);
      checkOutput({tag, " pc_plus"}, bus.pc_plus, pc + 32'd4);
      checkOutput({tag, " ras_top"}, bus.ras_top, top);
      checkOutput({tag, " ras_count"}, 32'(bus.ras_count), 32'(cnt));
      checkOutput({tag, " ras_empty"}, 32'(bus.ras_empty), (cnt == 0) ? 32'd1 : 32'd0);
   endtask

   // Drives one vector just after a rising edge, lets the falling edge act, then returns on the next rising edge.
   task automatic applyStimulus(input vec_t v);
      bus.stall           = v.stall;
      bus.redirect_valid  = v.rv;
      bus.redirect_target = v.target;
      bus.exc_valid       = v.exc;
      bus.call            = v.call;
      bus.ret             = v.ret;
      @(negedge CLK);
      @(posedge CLK);
   endtask

   initial begin
      numChecks = 0;
      numFails  = 0;
      RESET = 1'b1;
      bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = '0;
      bus.exc_valid = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;

      // stall rv target exc call ret | pc top count
      // Free-running from reset
      addVec(0, 0, 32'h0,         0, 0, 0, 32'h4,   32'h0,   0);
      addVec(0, 0, 32'h0,         0, 0, 0, 32'h8,   32'h0,   0);
      addVec(0, 0, 32'h0,         0, 0, 0, 32'hC,   32'h0,   0);
      // Stall, then redirect overriding stall with alignment
      addVec(0, 1, 32'h100,       0, 0, 0, 32'h100, 32'h0,   0);
      addVec(1, 0, 32'h0,         0, 0, 0, 32'h100, 32'h0,   0);
      addVec(1, 0, 32'h0,         0, 0, 0, 32'h100, 32'h0,   0);
      addVec(1, 1, 32'h203,       0, 0, 0, 32'h200, 32'h0,   0);
      // jal-style call with redirect, sequential, return
      addVec(0, 1, 32'h40,        0, 0, 0, 32'h40,  32'h0,   0);
      addVec(0, 1, 32'h80,        0, 1, 0, 32'h80,  32'h44,  1);
      addVec(0, 0, 32'h0,         0, 0, 0, 32'h84,  32'h44,  1);
      addVec(0, 0, 32'h0,         0, 0, 0, 32'h88,  32'h44,  1);
      addVec(0, 0, 32'h0,         0, 0, 1, 32'h44,  32'h0,   0);
      // Five calls saturate a depth-4 stack, oldest (0x48) overwritten
      addVec(0, 0, 32'h0,         0, 1, 0, 32'h48,  32'h48,  1);
      addVec(0, 0, 32'h0,         0, 1, 0, 32'h4C,  32'h4C,  2);
      addVec(0, 0, 32'h0,         0, 1, 0, 32'h50,  32'h50,  3);
      addVec(0, 0, 32'h0,         0, 1, 0, 32'h54,  32'h54,  4);
      addVec(0, 0, 32'h0,         0, 1, 0, 32'h58,  32'h58,  4);
      // LIFO pops, then a return on empty falls through sequentially
      addVec(0, 0, 32'h0,         0, 0, 1, 32'h58,  32'h54,  3);
      addVec(0, 0, 32'h0,         0, 0, 1, 32'h54,  32'h50,  2);
      addVec(0, 0, 32'h0,         0, 0, 1, 32'h50,  32'h4C,  1);
      addVec(0, 0, 32'h0,         0, 0, 1, 32'h4C,  32'h0,   0);
      addVec(0, 0, 32'h0,         0, 0, 1, 32'h50,  32'h0,   0);
      // Build top = 0x500, then call+ret together at pc 0x60
      addVec(0, 1, 32'h4FC,       0, 0, 0, 32'h4FC, 32'h0,   0);
      addVec(0, 0, 32'h0,         0, 1, 0, 32'h500, 32'h500, 1);
      addVec(0, 1, 32'h60,        0, 0, 0, 32'h60,  32'h500, 1);
      addVec(0, 0, 32'h0,         0, 1, 1, 32'h500, 32'h64,  1);
      // Fill to three entries, then exception with everything asserted
      addVec(0, 0, 32'h0,         0, 1, 0, 32'h504, 32'h504, 2);
      addVec(0, 0, 32'h0,         0, 1, 0, 32'h508, 32'h508, 3);
      addVec(0, 1, 32'h300,       1, 1, 1, 32'h180, 32'h0,   0);
      // Wrap at the top of the address space
      addVec(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 0);
      addVec(0, 0, 32'h0,         0, 0, 0, 32'h0,   32'h0,   0);
      // Return on empty with redirect, return with redirect, stalled call
      addVec(0, 1, 32'h10,        0, 0, 1, 32'h10,  32'h0,   0);
      addVec(0, 0, 32'h0,         0, 1, 0, 32'h14,  32'h14,  1);
      addVec(0, 1, 32'h30,        0, 0, 1, 32'h30,  32'h0,   0);
      addVec(1, 0, 32'h0,         0, 1, 0, 32'h30,  32'h0,   0);
      addVec(1, 0, 32'h0,         0, 0, 0, 32'h30,  32'h0,   0);

      // Reset state observed while reset is held
      @(posedge CLK);
      checkState("reset", 32'h0, 32'h0, 0);
      RESET = 1'b0;

      for (int i = 0; i < 3; i++) begin
         applyStimulus(vecs[i]);
         checkState($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expTop, vecs[i].expCount);
      end

      // Asynchronous reset mid-run: PC returns to the vector before any falling edge
      #2 RESET = 1'b1;
      #1 checkState("async reset", 32'h0, 32'h0, 0);
      @(posedge CLK);
      RESET = 1'b0;
      // Reset applied between vectors resumes at pc 4 on the next edge
      applyStimulus(vecs[0]);
      checkState("post reset", 32'h4, 32'h0, 0);

      for (int i = 3; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkState($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expTop, vecs[i].expCount);
      end

      // Reset with a non-empty stack clears entries so nothing stale resurfaces
      addVec(0, 0, 32'h0, 0, 1, 0, 32'h34, 32'h34, 1);
      applyStimulus(vecs[vecs.size() - 1]);
      checkState("push before reset", 32'h34, 32'h34, 1);
      #2 RESET = 1'b1;
      #1 checkState("reset flush", 32'h0, 32'h0, 0);
      @(posedge CLK);
      RESET = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
